lab1_imul_var_shift_mul: RTL and testbench

Iterative 32x32->32 integer multiplier with val/rdy request and response interfaces, consuming the 5-bit trailing-zero shift amount produced by the imul priority encoder. Each iteration adds the multiplicand when the current multiplier LSB is set, then skips directly to the next set multiplier bit. Latency therefore depends on the multiplier's bit pattern, not a fixed 32 cycles. Sits between the imul test source/sink (or processor MDU port) and the shared shift-amount encoder.

---
 rtl/lab1_imul_var_shift_mul_pkg.sv | 19 +
 rtl/lab1_imul_var_shift_mul_if.sv | 14 +
 rtl/lab1_imul_var_shift_mul_PriorityEncoder.sv | 17 +
 rtl/lab1_imul_var_shift_mul.sv | 96 +++++++++
 tb/tb_lab1_imul_var_shift_mul.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/lab1_imul_var_shift_mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package lab1_imul_pkg;

  localparam int unsigned OPW = 32;  // operand/result width
  localparam int unsigned SHW = 5;   // shift-amount width

  // req_msg = {a, b}
  localparam int unsigned REQ_A_MSB = 63;
  localparam int unsigned REQ_A_LSB = 32;
  localparam int unsigned REQ_B_MSB = 31;
  localparam int unsigned REQ_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lab1_imul_var_shift_mul_if.sv
// val/rdy request and response channels of the multiplier.
interface lab1_imul_var_shift_mul_if;
  logic        req_val;
  logic        req_rdy;
  logic [63:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  modport master (output req_val, req_msg, resp_rdy,
                  input  req_rdy, resp_val, resp_msg);
  modport slave  (input  req_val, req_msg, resp_rdy,
                  output req_rdy, resp_val, resp_msg);
endinterface

// File: rtl/lab1_imul_var_shift_mul_PriorityEncoder.sv
// Trailing-zero encoder: index of the lowest set bit in in_i[31:1], 0 if none.
module lab1_imul_PriorityEncoder
  import lab1_imul_pkg::*;
(
  input  logic [OPW-1:0] in_i,
  output logic [SHW-1:0] out_o
);

  // Scan high to low so the lowest set bit wins; bit 0 is deliberately ignored.
  always_comb begin
    out_o = '0;
    for (int i = OPW - 1; i >= 1; i--) begin
      if (in_i[i]) out_o = SHW'(i);
    end
  end

endmodule

// File: rtl/lab1_imul_var_shift_mul.sv
// Iterative 32x32->32 shift-add multiplier with val/rdy handshakes.
// Build option LAB1_IMUL_VARLAT_EN: skip runs of zero multiplier bits via the
// priority encoder (latency depends on b). Without it, shift by one for
// exactly 32 iterations.
module lab1_imul_var_shift_mul
  import lab1_imul_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  lab1_imul_var_shift_mul_if.slave io
);

  state_e         state_q, state_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [OPW-1:0] res_q, res_d;
  logic [SHW-1:0] shamt;
  logic           calc_last;
  logic           accept;

  assign accept = io.req_val && (state_q == IDLE);

`ifdef LAB1_IMUL_VARLAT_EN
  // Jump straight to the next set multiplier bit; no set bit above 0 ends CALC.
  lab1_imul_PriorityEncoder u_enc (
    .in_i  (b_q),
    .out_o (shamt)
  );
  assign calc_last = (shamt == '0);
`else
  logic [SHW-1:0] cnt_q;
  assign shamt     = SHW'(1);
  assign calc_last = (cnt_q == '1);

  // Iteration counter: 32 CALC cycles regardless of operand values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cnt_q <= '0;
    else if (state_q == CALC)  cnt_q <= cnt_q + SHW'(1);
    else                       cnt_q <= '0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = CALC;
      CALC:    if (calc_last)   state_d = DONE;
      DONE:    if (io.resp_rdy) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only (req_rdy also masked in reset).
  always_comb begin
    io.req_rdy  = reset_n && (state_q == IDLE);
    io.resp_val = (state_q == DONE);
    io.resp_msg = res_q;
  end

  // Datapath next-state: load on accept, add-and-shift while calculating.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (state_q == IDLE && accept) begin
      a_d   = io.req_msg[REQ_A_MSB:REQ_A_LSB];
      b_d   = io.req_msg[REQ_B_MSB:REQ_B_LSB];
      res_d = '0;
    end else if (state_q == CALC) begin
      if (b_q[0]) res_d = res_q + a_q;
      a_d = a_q << shamt;
      b_d = b_q >> shamt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_lab1_imul_var_shift_mul.sv
// Self-checking bench for lab1_imul_var_shift_mul: directed vectors, hand-written
// stall / reset sequences, and random operands against a plain-arithmetic model.
module tb_lab1_imul_var_shift_mul;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  lab1_imul_var_shift_mul_if bus ();

  lab1_imul_var_shift_mul dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  // Number of CALC cycles the multiplier should take for multiplier b.
  function automatic int model_lat(input logic [31:0] b);
`ifdef LAB1_IMUL_VARLAT_EN
    return $countones(b) + (b[0] ? 0 : 1);
`else
    return 32 + (b[0] & 1'b0);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // One complete transaction, driven and sampled on negedges.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input string nm);
    int k;
    bit got;
    k = 0;
    while (!bus.req_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " req_rdy"}, {31'd0, bus.req_rdy}, 32'd1);
    bus.req_val = 1'b1;
    bus.req_msg = {a, b};
    @(negedge clk);
    bus.req_val = 1'b0;
    bus.req_msg = {$urandom, $urandom};  // later changes must be ignored
    k = 1;
    got = 1'b0;
    while (k <= 200) begin
      if (bus.resp_val) begin
        got = 1'b1;
        break;
      end
      chk({nm, " busy req_rdy"}, {31'd0, bus.req_rdy}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk({nm, " resp seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({nm, " latency"}, k, model_lat(b) + 1);
      chk({nm, " result"}, bus.resp_msg, exp);
      for (int h = 0; h < hold; h++) begin
        bus.req_val = 1'b1;
        bus.req_msg = {$urandom, $urandom};
        @(negedge clk);
        chk({nm, " hold msg"}, bus.resp_msg, exp);
        chk({nm, " hold val"}, {31'd0, bus.resp_val}, 32'd1);
        chk({nm, " hold rdy"}, {31'd0, bus.req_rdy}, 32'd0);
      end
      bus.req_val  = 1'b0;
      bus.resp_rdy = 1'b1;
      @(negedge clk);
      bus.resp_rdy = 1'b0;
      chk({nm, " post resp_val"}, {31'd0, bus.resp_val}, 32'd0);
      chk({nm, " post req_rdy"}, {31'd0, bus.req_rdy}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit seen;
    bus.req_val  = 1'b0;
    bus.req_msg  = '0;
    bus.resp_rdy = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst req_rdy", {31'd0, bus.req_rdy}, 32'd0);
    chk("rst resp_val", {31'd0, bus.resp_val}, 32'd0);
    chk("rst resp_msg", bus.resp_msg, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-rst req_rdy", {31'd0, bus.req_rdy}, 32'd1);

    // Directed vectors; the 2x3 / 7x9 pair runs back to back after a stall.
    vecs.push_back('{32'd3,          32'd4,          32'd12,         0});
    vecs.push_back('{32'hDEADBEEF,   32'd0,          32'd0,          0});
    vecs.push_back('{32'd0,          32'hFFFFFFFF,   32'd0,          0});
    vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   0});
    vecs.push_back('{32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   0});
    vecs.push_back('{32'd5,          32'h80000000,   32'h80000000,   0});
    vecs.push_back('{32'd11,         32'd13,         32'd143,        5});
    vecs.push_back('{32'd2,          32'd3,          32'd6,          0});
    vecs.push_back('{32'd7,          32'd9,          32'd63,         0});
    vecs.push_back('{32'd1,          32'd1,          32'd1,          0});
    for (int i = 0; i < vecs.size(); i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset during the 3rd CALC cycle of 0xFFFF*0xFFFF drops the transaction.
    bus.req_val = 1'b1;
    bus.req_msg = {32'h0000FFFF, 32'h0000FFFF};
    @(negedge clk);
    bus.req_val = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst req_rdy", {31'd0, bus.req_rdy}, 32'd0);
    chk("midrst resp_val", {31'd0, bus.resp_val}, 32'd0);
    chk("midrst resp_msg", bus.resp_msg, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.resp_val || !bus.req_rdy) seen = 1'b1;
    end
    chk("dropped txn silent", {31'd0, seen}, 32'd0);
    run_txn(32'd6, 32'd7, 32'd42, 0, "after rst");

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = $urandom & $urandom & $urandom;
        2:       rb = 32'd1 << $urandom_range(31, 0);
        default: rb = ~($urandom & $urandom);
      endcase
      run_txn(ra, rb, ra * rb, (i % 7 == 0) ? 2 : 0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
